// File: rtl/ahb_dma_copy.sv
// ============================================================================
// Module   : ahb_dma_copy
// Brief    : Single-channel AHB-Lite master copying a block of 32-bit words
//            from src to dst, one read then one write per word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_dma_copy #(
    parameter int LENW = 16
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            start,
    input  logic [31:0]     src,
    input  logic [31:0]     dst,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [31:0]     HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [31:0]     HWDATA,
    input  logic            HREADY,
    input  logic [31:0]     HRDATA,
    input  logic            HRESP
);

    localparam logic [1:0]  c_TRANS_IDLE   = 2'b00;
    localparam logic [1:0]  c_TRANS_NONSEQ = 2'b10;
    localparam logic [31:0] c_ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] c_WORD_BYTES   = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RA   = 3'd1,
        ST_RD   = 3'd2,
        ST_WA   = 3'd3,
        ST_WD   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_src;
    logic [31:0]     r_dst;
    logic [LENW-1:0] r_cnt;
    logic [31:0]     r_data;

    logic [31:0]     w_src;
    logic [31:0]     w_dst;
    logic [LENW-1:0] w_cnt;
    logic [31:0]     w_data;
    logic [31:0]     w_haddr;
    logic [1:0]      w_htrans;
    logic            w_hwrite;
    logic [31:0]     w_hwdata;
    logic            w_done;
    logic            w_err;

    // Single word size, single transfers only.
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;

    // Next-state and next-output decode; every bus output is registered from these.
    always_comb begin
        w_state_nxt = r_state;
        w_src       = r_src;
        w_dst       = r_dst;
        w_cnt       = r_cnt;
        w_data      = r_data;
        w_haddr     = HADDR;
        w_htrans    = c_TRANS_IDLE;
        w_hwrite    = HWRITE;
        w_hwdata    = HWDATA;
        w_done      = 1'b0;
        w_err       = err;

        case (r_state)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done) begin
                    w_err = 1'b0;
                    if (len == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_src       = src & c_ALIGN_MASK;
                        w_dst       = dst & c_ALIGN_MASK;
                        w_cnt       = len;
                        w_haddr     = src & c_ALIGN_MASK;
                        w_htrans    = c_TRANS_NONSEQ;
                        w_hwrite    = 1'b0;
                        w_state_nxt = ST_RA;
                    end
                end
            end
            ST_RA: begin
                if (HREADY) begin
                    w_state_nxt = ST_RD;
                end else begin
                    w_htrans = c_TRANS_NONSEQ;
                end
            end
            ST_RD: begin
                if (HREADY) begin
                    if (HRESP) begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                        w_err       = 1'b1;
                    end else begin
                        w_data      = HRDATA;
                        w_haddr     = r_dst;
                        w_htrans    = c_TRANS_NONSEQ;
                        w_hwrite    = 1'b1;
                        w_state_nxt = ST_WA;
                    end
                end
            end
            ST_WA: begin
                if (HREADY) begin
                    w_hwdata    = r_data;
                    w_state_nxt = ST_WD;
                end else begin
                    w_htrans = c_TRANS_NONSEQ;
                end
            end
            ST_WD: begin
                if (HREADY) begin
                    if (HRESP) begin
                        // Failed word is not counted; pointers stay put.
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                        w_err       = 1'b1;
                    end else begin
                        w_src = r_src + c_WORD_BYTES;
                        w_dst = r_dst + c_WORD_BYTES;
                        w_cnt = r_cnt - LENW'(1);
                        if (r_cnt == LENW'(1)) begin
                            w_state_nxt = ST_IDLE;
                            w_done      = 1'b1;
                        end else begin
                            w_haddr     = r_src + c_WORD_BYTES;
                            w_htrans    = c_TRANS_NONSEQ;
                            w_hwrite    = 1'b0;
                            w_state_nxt = ST_RA;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointers and registered outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            HADDR   <= '0;
            HTRANS  <= c_TRANS_IDLE;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src;
            r_dst   <= w_dst;
            r_cnt   <= w_cnt;
            r_data  <= w_data;
            busy    <= (w_state_nxt != ST_IDLE);
            done    <= w_done;
            err     <= w_err;
            HADDR   <= w_haddr;
            HTRANS  <= w_htrans;
            HWRITE  <= w_hwrite;
            HWDATA  <= w_hwdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_dma_copy.sv
// ============================================================================
// Module   : tb_ahb_dma_copy
// Brief    : Directed bench for ahb_dma_copy with a small AHB-Lite memory slave
//            (wait states and two-cycle ERROR injection).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_dma_copy;

    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    logic        start  = 1'b0;
    logic [31:0] src    = '0;
    logic [31:0] dst    = '0;
    logic [15:0] len    = '0;
    logic        busy, done, err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = '0;
    logic        HRESP  = 1'b0;

    ahb_dma_copy #(.LENW(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Slave model state
    logic [31:0] mem [0:1023];
    logic [32:0] trace [$];
    int          waits   = 0;
    int          err_at  = 0;
    int          wr_total = 0;
    int          stab_viol = 0;
    int          stab_seen = 0;
    logic        dp_active = 1'b0;
    logic [31:0] dp_addr   = '0;
    logic        dp_write  = 1'b0;
    int          dp_wait   = 0;
    logic        dp_err    = 1'b0;
    logic        err_stage = 1'b0;
    logic [31:0] p_haddr   = '0;
    logic [1:0]  p_htrans  = '0;
    logic [31:0] p_hwdata  = '0;

    // Memory slave: responses are decided at the falling edge for the coming rising edge.
    always @(negedge HCLK) begin
        if (HREADY == 1'b0) begin
            stab_seen++;
            if (HADDR !== p_haddr || HTRANS !== p_htrans || HWDATA !== p_hwdata) stab_viol++;
        end
        p_haddr  = HADDR;
        p_htrans = HTRANS;
        p_hwdata = HWDATA;
        if (dp_active) begin
            if (dp_err) begin
                HRESP = 1'b1;
                if (!err_stage) begin
                    HREADY    = 1'b0;
                    err_stage = 1'b1;
                end else begin
                    HREADY    = 1'b1;
                    dp_active = 1'b0;
                end
            end else if (dp_wait > 0) begin
                HREADY = 1'b0;
                HRESP  = 1'b0;
                dp_wait--;
            end else begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
                HRDATA = mem[dp_addr[11:2]];
                if (dp_write) mem[dp_addr[11:2]] = HWDATA;
                dp_active = 1'b0;
            end
        end else begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
        end
        if (HREADY && HTRANS == 2'b10) begin
            trace.push_back({HWRITE, HADDR});
            dp_active = 1'b1;
            dp_addr   = HADDR;
            dp_write  = HWRITE;
            dp_wait   = waits;
            err_stage = 1'b0;
            dp_err    = 1'b0;
            if (HWRITE) begin
                wr_total++;
                if (wr_total == err_at) dp_err = 1'b1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int base   = 0;
    int t0     = 0;
    int lat    = 0;
    int dseen  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[11:2]];
    endfunction

    task automatic wait_done(output int l);
        l = -1;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                l = cyc - t0;
                break;
            end
            @(negedge HCLK);
        end
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, output int lt);
        @(negedge HCLK);
        src = s; dst = d; len = l; start = 1'b1;
        t0 = cyc; base = trace.size();
        @(negedge HCLK);
        start = 1'b0;
        wait_done(lt);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(negedge HCLK);

        // Reset state
        chk("rst_busy",   64'(busy),   64'h0);
        chk("rst_done",   64'(done),   64'h0);
        chk("rst_err",    64'(err),    64'h0);
        chk("rst_haddr",  64'(HADDR),  64'h0);
        chk("rst_htrans", 64'(HTRANS), 64'h0);
        chk("rst_hwrite", 64'(HWRITE), 64'h0);
        chk("rst_hwdata", 64'(HWDATA), 64'h0);
        chk("rst_hsize",  64'(HSIZE),  64'h2);
        chk("rst_hburst", 64'(HBURST), 64'h0);
        HRESET = 1'b0;

        // Zero-wait copy of four words
        mem[32'h100 >> 2] = 32'h1111_1111;
        mem[32'h104 >> 2] = 32'h2222_2222;
        mem[32'h108 >> 2] = 32'h3333_3333;
        mem[32'h10C >> 2] = 32'h4444_4444;
        run(32'h100, 32'h200, 16'd4, lat);
        chk("zw_latency", 64'(lat), 64'd17);
        chk("zw_busy_at_done", 64'(busy), 64'h0);
        chk("zw_err", 64'(err), 64'h0);
        chk("zw_m200", 64'(rd(32'h200)), 64'h1111_1111);
        chk("zw_m204", 64'(rd(32'h204)), 64'h2222_2222);
        chk("zw_m208", 64'(rd(32'h208)), 64'h3333_3333);
        chk("zw_m20C", 64'(rd(32'h20C)), 64'h4444_4444);
        chk("zw_ntrans", 64'(trace.size() - base), 64'd8);
        chk("zw_t0", 64'(trace[base+0]), 64'h0_0000_0100);
        chk("zw_t1", 64'(trace[base+1]), 64'h1_0000_0200);
        chk("zw_t2", 64'(trace[base+2]), 64'h0_0000_0104);
        chk("zw_t3", 64'(trace[base+3]), 64'h1_0000_0204);
        chk("zw_t6", 64'(trace[base+6]), 64'h0_0000_010C);
        chk("zw_t7", 64'(trace[base+7]), 64'h1_0000_020C);

        // Two wait states on every data phase
        mem[32'h300 >> 2] = 32'hA0A0_A0A0;
        mem[32'h304 >> 2] = 32'hB0B0_B0B0;
        @(negedge HCLK);
        waits = 2;
        stab_viol = 0;
        stab_seen = 0;
        run(32'h300, 32'h380, 16'd2, lat);
        chk("ws_latency", 64'(lat), 64'd17);
        chk("ws_stable_viol", 64'(stab_viol), 64'd0);
        chk("ws_wait_cycles", 64'(stab_seen), 64'd8);
        chk("ws_m380", 64'(rd(32'h380)), 64'hA0A0_A0A0);
        chk("ws_m384", 64'(rd(32'h384)), 64'hB0B0_B0B0);
        @(negedge HCLK);
        waits = 0;

        // Zero length with misaligned source
        run(32'h103, 32'h200, 16'd0, lat);
        chk("zl_latency", 64'(lat), 64'd1);
        chk("zl_err", 64'(err), 64'h0);
        chk("zl_busy", 64'(busy), 64'h0);
        repeat (2) @(negedge HCLK);
        chk("zl_ntrans", 64'(trace.size() - base), 64'd0);
        run(32'h103, 32'h400, 16'd1, lat);
        chk("mis_latency", 64'(lat), 64'd5);
        chk("mis_first_addr", 64'(trace[base]), 64'h0_0000_0100);
        chk("mis_m400", 64'(rd(32'h400)), 64'h1111_1111);

        // ERROR on the write of word 2 of 3
        mem[32'h500 >> 2] = 32'h5555_0001;
        mem[32'h504 >> 2] = 32'h5555_0002;
        mem[32'h508 >> 2] = 32'h5555_0003;
        @(negedge HCLK);
        err_at = wr_total + 2;
        run(32'h500, 32'h600, 16'd3, lat);
        chk("er_latency", 64'(lat), 64'd10);
        chk("er_err", 64'(err), 64'h1);
        chk("er_busy", 64'(busy), 64'h0);
        repeat (4) @(negedge HCLK);
        chk("er_ntrans", 64'(trace.size() - base), 64'd4);
        chk("er_m600", 64'(rd(32'h600)), 64'h5555_0001);
        chk("er_m604", 64'(rd(32'h604)), 64'h0);
        chk("er_err_sticky", 64'(err), 64'h1);
        err_at = 0;

        // Wrap-around with an ignored second start
        mem[32'h3FF] = 32'hCAFE_0001;
        mem[0]       = 32'hCAFE_0002;
        @(negedge HCLK);
        src = 32'hFFFF_FFFC; dst = 32'h700; len = 16'd2; start = 1'b1;
        t0 = cyc; base = trace.size();
        @(negedge HCLK);
        start = 1'b0;
        chk("wr_err_cleared", 64'(err), 64'h0);
        chk("wr_busy", 64'(busy), 64'h1);
        repeat (2) @(negedge HCLK);
        src = 32'h800; dst = 32'h900; len = 16'd5; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        wait_done(lat);
        chk("wr_latency", 64'(lat), 64'd9);
        // Start in the done cycle must be dropped
        src = 32'h100; dst = 32'hC00; len = 16'd1; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        chk("dc_busy", 64'(busy), 64'h0);
        repeat (3) @(negedge HCLK);
        chk("wr_ntrans", 64'(trace.size() - base), 64'd4);
        chk("wr_t0", 64'(trace[base+0]), 64'h0_FFFF_FFFC);
        chk("wr_t2", 64'(trace[base+2]), 64'h0_0000_0000);
        chk("wr_t3", 64'(trace[base+3]), 64'h1_0000_0704);
        chk("wr_m700", 64'(rd(32'h700)), 64'hCAFE_0001);
        chk("wr_m704", 64'(rd(32'h704)), 64'hCAFE_0002);

        // Reset during WA of word 3
        @(negedge HCLK);
        src = 32'h100; dst = 32'hA00; len = 16'd4; start = 1'b1;
        t0 = cyc;
        @(negedge HCLK);
        start = 1'b0;
        repeat (10) @(negedge HCLK);
        chk("rm_in_wa", 64'({HTRANS, HWRITE}), 64'h5);
        chk("rm_wa_addr", 64'(HADDR), 64'h0000_0A08);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("rm_htrans", 64'(HTRANS), 64'h0);
        chk("rm_busy", 64'(busy), 64'h0);
        chk("rm_done", 64'(done), 64'h0);
        HRESET = 1'b0;
        dseen = 0;
        base = trace.size();
        repeat (6) begin
            @(negedge HCLK);
            if (done) dseen++;
        end
        chk("rm_no_done", 64'(dseen), 64'd0);
        chk("rm_no_resume", 64'(trace.size() - base), 64'd0);
        run(32'h100, 32'hB00, 16'd2, lat);
        chk("rm_new_latency", 64'(lat), 64'd9);
        chk("rm_mB00", 64'(rd(32'hB00)), 64'h1111_1111);
        chk("rm_mB04", 64'(rd(32'hB04)), 64'h2222_2222);
        chk("rm_new_err", 64'(err), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
